// File: rtl/encrypt_scheduler.sv
// Round-robin front end sharing one 5-stage encryption core between two requesters.
// Holds a key per requester and tags every beat so results route back to their issuer.
module encrypt_scheduler #(
  parameter int N   = 8,
  parameter int LAT = 5
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_data0,
  input  logic [N-1:0] req_data1,
  input  logic         key_we,
  input  logic         key_sel,
  input  logic [N-1:0] key_wdata,
  input  logic         hold,
  output logic [N-1:0] core_data,
  output logic [N-1:0] core_key,
  input  logic [N-1:0] core_e_data,
  output logic [1:0]   rsp_valid,
  output logic [N-1:0] rsp_data,
  output logic         idle
);

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  logic [N-1:0]     key0;
  logic [N-1:0]     key1;
  logic             ptr;
  tag_t [LAT-1:0]   tags;
  logic             grant_any;
  logic             grant_id;

  // Grant logic; forced to zero while reset is asserted so no beat is offered mid-reset.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    req_ready = 2'b00;
    if (reset_n && !hold) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = ptr ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign grant_any = |req_ready;
  assign grant_id  = req_ready[1];

  assign core_data = !grant_any ? '0 : (grant_id ? req_data1 : req_data0);
  assign core_key  = !grant_any ? '0 : (grant_id ? key1 : key0);

  // Keys are read combinationally above, so a same-edge write only affects later grants.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key0 <= '0;
      key1 <= '0;
      ptr  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
      if (key_we && !key_sel) key0 <= key_wdata;
      if (key_we &&  key_sel) key1 <= key_wdata;
      if (grant_any)          ptr  <= !grant_id;
    end
  end

  // Tag pipeline moves in lockstep with the core stages; entry LAT-1 matches e_data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: only the tag valids need reset; stale core data is harmless once its tag is gone.
      tags <= '0;
    end else begin
      tags[0] <= '{valid: grant_any, id: grant_id};
      for (int k = 1; k < LAT; k++) begin
        tags[k] <= tags[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (tags[LAT-1].valid) begin
      rsp_valid = tags[LAT-1].id ? 2'b10 : 2'b01;
    end
  end

  assign rsp_data = core_e_data;

  always_comb begin
    idle = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      if (tags[k].valid) idle = 1'b0;
    end
  end

endmodule

// File: doc/encrypt_scheduler.md
# encrypt_scheduler

Round-robin scheduler that shares one `encryption` pipeline (N-bit, 5-stage, no stall, no valid) between two requesters. It holds one programmable key per requester and muxes the granted requester's data and key into the core each cycle. A tag pipeline runs in lockstep with the core's stage registers, so each result is routed back to the requester that issued it. It sits between the two host-side data streams and the `encryption` instance it drives.

## Interface
- `N`, default 8: data/key width; must be even and match the core's `N`.
- `LAT`, default 5: core latency in clock edges, counted from the edge that captures the input to the edge that updates `e_data`.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  bit i: requester i presents a beat.
- `req_ready`  out  2  bit i: beat i is accepted at this edge (one-hot or zero).
- `req_data0`, `req_data1`  in  N  plaintext from each requester.
- `key_we`  in  1  key write strobe.
- `key_sel`  in  1  key slot selected for writing.
- `key_wdata`  in  N  new key value.
- `hold`  in  1  suppresses all new grants; in-flight beats still drain.
- `core_data`, `core_key`  out  N  drive the core's `data` and `key` inputs.
- `core_e_data`  in  N  the core's `e_data` output.
- `rsp_valid`  out  2  bit i: a result for requester i is on `rsp_data` this cycle.
- `rsp_data`  out  N  equals `core_e_data`.
- `idle`  out  1  no valid tag is in flight.

## Operation
- Key registers `key0` and `key1` reset to 0.
  - `key_we` writes `key_wdata` into slot `key_sel` at the edge.
  - The new key applies to beats granted after that edge. A beat granted on the write edge uses the old key.
- Arbiter state: a 1-bit priority pointer `ptr`, reset to 0. It points at the favoured requester.
  - `hold` = 1: `req_ready` = 00.
  - Only one `req_valid` set: grant that requester.
  - Both set: grant requester `ptr`.
  - After any grant to requester g, `ptr` becomes !g at the edge. With no grant, `ptr` holds.
- `req_ready` is combinational from `req_valid`, `hold` and `ptr`. `req_ready` may rise without `req_valid`? No: it never asserts for a requester whose `req_valid` is low.
- Core drive when requester g is granted: `core_data` = `req_data<g>`, `core_key` = `key<g>`. With no grant, both are 0.
- Tag pipeline: LAT entries of {valid, id}, all reset to invalid.
  - Each edge, entry 0 takes {grant_any, g} and entry k takes entry k-1.
  - Entry 0 is therefore aligned with core stage S1, and entry LAT-1 with S5.
- `rsp_valid[i]` = entry LAT-1 valid and id == i. `rsp_data` = `core_e_data` unconditionally. There is no response backpressure: requesters must sink results when `rsp_valid` is high.
- `idle` = no entry of the tag pipeline is valid.

## Timing
- Beat accepted at edge k → `rsp_valid` high for exactly the one cycle after edge k+LAT-1 (k+4 at the default LAT).
- Throughput is one beat per cycle, total across both requesters.
  - With both requesters continuously valid, grants alternate 0,1,0,1…
  - One requester continuously valid and alone gets every cycle.
- Reset asserted mid-operation:
  - `req_ready` = 00, `rsp_valid` = 00, `idle` = 1, `ptr` = 0, keys = 0, all tags invalid, asynchronously and immediately.
  - Any in-flight core contents are discarded: they never raise `rsp_valid`.
- `hold` rising while beats are in flight: no new grants are made; the existing beats complete; `idle` rises LAT cycles after the last grant.
- `key_we` and a grant to the same slot in one cycle: the beat uses the old key. A beat granted in the next cycle uses the new key.
- Simultaneous response and new request never conflict: they are independent ends of the pipeline.

## Test plan
- Reset, then requester 0 sends 0x01 with `key0` = 0x00 → `rsp_valid` = 01 after 5 edges, `rsp_data` = 0xF7; `idle` low for exactly those 5 cycles.
- Write `key1` = 0xA5, then requester 1 sends 0x3C → `rsp_valid` = 10, `rsp_data` = 0x66.
- Both requesters valid for 6 cycles → grants 0,1,0,1,0,1; responses return in the same order, each tagged to its own requester, back-to-back.
- Write `key0` from 0x00 to 0xFF on the edge that grants 0x01, then send 0x01 again next cycle → results 0xF7 (old key), then 0x10 (new key).
- Assert `hold` with 3 beats in flight → no `req_ready` while `hold` is high; the 3 responses still arrive; `idle` = 1 afterwards.
- Pulse `reset_n` low with 4 beats in flight → `rsp_valid` stays 00 through the following 5 cycles; the next beat after reset returns normally.
